reshape_hls_deadlock_report_unit: RTL

Central collector placed directly downstream of the per-process deadlock detect units in the Reshape_HLS dataflow region. Consumes every unit's `dl_detect_out`, confirms a sustained detection, broadcasts `dl_detect_in`, launches the report token from one origin process and closes the loop with `token_clear`. It then serialises the indices of all processes on the deadlock cycle through a valid/ready report port. Once a deadlock is confirmed, the block stays latched until reset.

---
 rtl/reshape_hls_deadlock_report_unit.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/reshape_hls_deadlock_report_unit.sv
// ---------------------------------------------------------------------------
// reshape_hls_deadlock_report_unit
//
// Central collector for the per-process deadlock detect units of the
// Reshape_HLS dataflow region. It watches every unit's dl_detect_out and
// confirms that some detection has been sustained long enough. It then
// locks and broadcasts dl_detect_in, and launches the report token from one
// origin process. While the token travels it accumulates every process that
// reports back. The loop closes when the origin sees its token again
// (token_clear), or the trace times out. The collected process indices are
// then streamed out in ascending order over a valid/ready port. After that
// the block parks in HALT until reset.
//
// Parameters
//   PROC_NUM        number of detect units / processes (>= 2)
//   CONFIRM_CYCLES  consecutive cycles of |dl_detect_vec needed to lock (>= 1)
//   TRACE_TIMEOUT   maximum TRACE cycles before a partial report (>= 1)
//
// Ports
//   clock           rising-edge clock
//   reset           asynchronous, active-high reset
//   dl_detect_vec   bit p = dl_detect_out of process p
//   dl_detect_in    broadcast to all detect units, high once locked
//   origin          one-hot pulse to the origin unit during the lock cycle
//   token_clear     combinational; origin's token returned during TRACE
//   dl_detected     status copy of dl_detect_in
//   report_valid    report entry available
//   report_ready    consumer accepts the current entry
//   report_idx      process index of the current entry
//   report_last     current entry is the final one
//   report_partial  report was produced by timeout, not by loop closure
// ---------------------------------------------------------------------------
module reshape_hls_deadlock_report_unit #(
  parameter int PROC_NUM       = 4,
  parameter int CONFIRM_CYCLES = 3,
  parameter int TRACE_TIMEOUT  = 64,
  localparam int IDX_W = ($clog2(PROC_NUM) < 1) ? 1 : $clog2(PROC_NUM)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_detect_vec,
  output logic                dl_detect_in,
  output logic [PROC_NUM-1:0] origin,
  output logic                token_clear,
  output logic                dl_detected,
  output logic                report_valid,
  input  logic                report_ready,
  output logic [IDX_W-1:0]    report_idx,
  output logic                report_last,
  output logic                report_partial
);

  // Counter widths sized so the terminal value itself is representable.
  localparam int CNT_W = $clog2(CONFIRM_CYCLES + 1);
  localparam int TMO_W = $clog2(TRACE_TIMEOUT + 1);

  localparam logic [PROC_NUM-1:0] VEC_ONE = PROC_NUM'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIRM,
    S_LOCKED,
    S_TRACE,
    S_REPORT,
    S_HALT
  } state_t;

  state_t               state_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [TMO_W-1:0]     tmo_reg;
  logic [IDX_W-1:0]     origin_idx_reg;
  // Accumulates the cycle membership during TRACE, then serves as the
  // remaining-entries set during REPORT (entries are cleared as accepted).
  logic [PROC_NUM-1:0]  bitmap_reg;
  logic [PROC_NUM-1:0]  origin_reg;
  logic                 dl_detect_in_reg;
  logic                 report_partial_reg;

  logic                 any_detect;
  logic [IDX_W-1:0]     detect_low_idx;
  logic [PROC_NUM-1:0]  detect_low_onehot;
  logic [PROC_NUM-1:0]  origin_sel;
  logic [CNT_W-1:0]     cnt_next;
  logic [TMO_W-1:0]     tmo_next;
  logic [PROC_NUM-1:0]  rem_cleared;
  logic [IDX_W-1:0]     rem_low_idx;
  logic                 rem_single;
  logic                 in_report;
  logic                 report_fire;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [PROC_NUM-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  assign any_detect     = |dl_detect_vec;
  assign detect_low_idx = lowest_idx(dl_detect_vec);
  assign cnt_next       = cnt_reg + CNT_W'(1);
  assign tmo_next       = tmo_reg + TMO_W'(1);

  // One-hot decodes of the freshly sampled origin candidate and of the
  // latched origin index.
  genvar gi;
  generate
    for (gi = 0; gi < PROC_NUM; gi++) begin : g_onehot
      assign detect_low_onehot[gi] = (detect_low_idx == IDX_W'(gi));
      assign origin_sel[gi]        = (origin_idx_reg == IDX_W'(gi));
    end
  endgenerate

  // x & (x-1) drops the lowest set bit: it is both the post-accept set
  // and, when zero, the marker that only one entry is left.
  assign rem_cleared = bitmap_reg & (bitmap_reg - VEC_ONE);
  assign rem_single  = (bitmap_reg != '0) && (rem_cleared == '0);
  assign rem_low_idx = lowest_idx(bitmap_reg);

  assign in_report   = (state_reg == S_REPORT);
  assign report_fire = report_valid && report_ready;

  // The returning token is only meaningful while tracing; in LOCKED the
  // origin's own detect bit may still be high from before the launch.
  assign token_clear = (state_reg == S_TRACE) && |(dl_detect_vec & origin_sel);

  assign report_valid   = in_report && (bitmap_reg != '0);
  assign report_idx     = in_report ? rem_low_idx : '0;
  assign report_last    = in_report && rem_single;
  assign report_partial = report_partial_reg;
  assign dl_detect_in   = dl_detect_in_reg;
  assign dl_detected    = dl_detect_in_reg;
  assign origin         = origin_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg          <= S_IDLE;
      cnt_reg            <= '0;
      tmo_reg            <= '0;
      origin_idx_reg     <= '0;
      bitmap_reg         <= '0;
      origin_reg         <= '0;
      dl_detect_in_reg   <= 1'b0;
      report_partial_reg <= 1'b0;
    end else begin
      // origin is a single-cycle pulse; it is only raised on entry to LOCKED.
      origin_reg <= '0;

      case (state_reg)
        S_IDLE: begin
          if (any_detect) begin
            cnt_reg        <= CNT_W'(1);
            origin_idx_reg <= detect_low_idx;
            if (CONFIRM_CYCLES == 1) begin
              state_reg        <= S_LOCKED;
              origin_reg       <= detect_low_onehot;
              dl_detect_in_reg <= 1'b1;
            end else begin
              state_reg <= S_CONFIRM;
            end
          end
        end

        S_CONFIRM: begin
          if (!any_detect) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
          end else begin
            // The origin follows the most recent sample, so the process
            // pulsed is the one still detecting when the lock happens.
            cnt_reg        <= cnt_next;
            origin_idx_reg <= detect_low_idx;
            if (cnt_next == CNT_W'(CONFIRM_CYCLES)) begin
              state_reg        <= S_LOCKED;
              origin_reg       <= detect_low_onehot;
              dl_detect_in_reg <= 1'b1;
            end
          end
        end

        S_LOCKED: begin
          bitmap_reg <= origin_sel;
          tmo_reg    <= '0;
          state_reg  <= S_TRACE;
        end

        S_TRACE: begin
          // The exit cycle's sample is still merged, so every process that
          // reported in the closing/timeout cycle appears in the report.
          bitmap_reg <= bitmap_reg | dl_detect_vec;
          if (token_clear) begin
            state_reg          <= S_REPORT;
            report_partial_reg <= 1'b0;
          end else if (tmo_next == TMO_W'(TRACE_TIMEOUT)) begin
            state_reg          <= S_REPORT;
            report_partial_reg <= 1'b1;
          end else begin
            tmo_reg <= tmo_next;
          end
        end

        S_REPORT: begin
          if (report_fire) begin
            bitmap_reg <= rem_cleared;
            if (rem_single) state_reg <= S_HALT;
          end
        end

        S_HALT: begin
          // Latched until reset.
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule
